lanes_serializer: RTL

Transmit-side lane serializer for the two-lane link. It samples one parallel word per lane from the transmit encoder/scrambler path and shifts it onto the serial lane outputs, LSB first. Frame length is selected by gen_speed: 8 bits (Gen4), 132 bits (Gen3) or 66 bits (Gen2). Lanes 0 and 1 are serialized in lockstep, and the block exposes load and scrambler-reseed strobes to the upstream stage.

---
 rtl/lanes_serializer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lanes_serializer.sv
// -----------------------------------------------------------------------------
// lanes_serializer
//
// Transmit-side serializer for a two-lane link. On a load edge it samples one
// parallel word per lane and then shifts both words out in lockstep, LSB
// first, one bit per clock. The frame length N is chosen by gen_speed when a
// word is loaded and stays fixed until that word has been fully sent:
//   00 / 11 -> Gen4, N = 8
//   01      -> Gen3, N = 132
//   10      -> Gen2, N = 66
//
// Ports
//   clk            clock; all state changes on the rising edge
//   rst            asynchronous, active-low reset
//   enable         serialization enable; low clears all state at each edge
//   gen_speed      frame length select, sampled only on a load edge
//   Lane_0_tx_in   parallel word, lane 0 (bits [N-1:0] used)
//   Lane_1_tx_in   parallel word, lane 1 (bits [N-1:0] used)
//   Lane_0_tx_out  serial data, lane 0 (registered)
//   Lane_1_tx_out  serial data, lane 1 (registered)
//   load_ack       high when the input words are captured at this edge
//   scr_rst        upstream scrambler reseed strobe (counter == N-2)
//   tx_active      high while valid serial bits are on the outputs
// -----------------------------------------------------------------------------
module lanes_serializer (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [1:0]   gen_speed,
    input  logic [131:0] Lane_0_tx_in,
    input  logic [131:0] Lane_1_tx_in,
    output logic         Lane_0_tx_out,
    output logic         Lane_1_tx_out,
    output logic         load_ack,
    output logic         scr_rst,
    output logic         tx_active
);

    typedef enum logic [1:0] {
        GEN4     = 2'b00,
        GEN3     = 2'b01,
        GEN2     = 2'b10,
        GEN_RSVD = 2'b11
    } gen_e;

    localparam logic [7:0] LEN_GEN4 = 8'd8;
    localparam logic [7:0] LEN_GEN3 = 8'd132;
    localparam logic [7:0] LEN_GEN2 = 8'd66;

    // Bit position within the current word; 0 means "idle / load next".
    logic [7:0]   counter;
    // Frame length latched at the load edge of the word in flight.
    logic [7:0]   frame_len;
    logic [131:0] shift_0;
    logic [131:0] shift_1;

    // Frame length and input mask selected by the current gen_speed; only
    // consumed on a load edge.
    logic [7:0]   sel_len;
    logic [131:0] sel_mask;
    logic         load;
    logic         last_bit;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        sel_len  = LEN_GEN4;
        sel_mask = {{124{1'b0}}, {8{1'b1}}};
        case (gen_e'(gen_speed))
            GEN3: begin
                sel_len  = LEN_GEN3;
                sel_mask = {132{1'b1}};
            end
            GEN2: begin
                sel_len  = LEN_GEN2;
                sel_mask = {{66{1'b0}}, {66{1'b1}}};
            end
            default: ;  // GEN4 and the reserved code both use 8-bit frames
        endcase
    end

    assign load     = enable && (counter == 8'd0);
    assign last_bit = (counter == frame_len - 8'd1);

    // The strobes are gated with rst so that they stay low while reset is
    // held, whatever enable is doing.
    assign load_ack = rst && load;
    assign scr_rst  = rst && enable && (counter == frame_len - 8'd2);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter       <= 8'd0;
            frame_len     <= LEN_GEN4;
            shift_0       <= '0;
            shift_1       <= '0;
            Lane_0_tx_out <= 1'b0;
            Lane_1_tx_out <= 1'b0;
            tx_active     <= 1'b0;
        end else if (!enable) begin
            // Synchronous idle: abandon any word in flight.
            counter       <= 8'd0;
            frame_len     <= LEN_GEN4;
            shift_0       <= '0;
            shift_1       <= '0;
            Lane_0_tx_out <= 1'b0;
            Lane_1_tx_out <= 1'b0;
            tx_active     <= 1'b0;
        end else if (load) begin
            // Bit 0 goes straight to the output; the rest waits in the shift
            // register. Bits at or above N are masked off so stale upper bits
            // can never leak out.
            Lane_0_tx_out <= Lane_0_tx_in[0];
            Lane_1_tx_out <= Lane_1_tx_in[0];
            shift_0       <= (Lane_0_tx_in & sel_mask) >> 1;
            shift_1       <= (Lane_1_tx_in & sel_mask) >> 1;
            frame_len     <= sel_len;
            counter       <= 8'd1;
            tx_active     <= 1'b1;
        end else begin
            Lane_0_tx_out <= shift_0[0];
            Lane_1_tx_out <= shift_1[0];
            shift_0       <= shift_0 >> 1;
            shift_1       <= shift_1 >> 1;
            // Wrapping to 0 after bit N-1 makes the next edge a load edge,
            // giving back-to-back words with no gap.
            counter       <= last_bit ? 8'd0 : counter + 8'd1;
        end
    end

endmodule
